dir_cmd_queue: RTL and testbench

//  Consumer side of the key-press pulse interface. Takes the one-cycle left/right/up/down

---
 rtl/snake_pkg.sv | 16 +
 rtl/dir_fifo.sv | 80 ++++++++
 rtl/dir_cmd_queue.sv | 128 ++++++++++++
 tb/tb_dir_cmd_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game blocks (queue, movement, renderer).
package snake_pkg;

    localparam int DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

    // Opposite direction: the encoding pairs UP/DOWN and LEFT/RIGHT on bit 0.
    function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular buffer of direction commands with head/tail peek and occupancy count.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DIR_W-1:0]             wdata,
    output logic [DIR_W-1:0]             head,
    output logic [DIR_W-1:0]             tail,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DIR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic do_pop_s;
    logic do_push_s;

    // Qualify pop against empty and push against full; a same-cycle pop frees a slot.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (count_r != CNT_W'(0))) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r < CNT_W'(DEPTH)) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage write at the tail slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DIR_UP;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign tail  = mem_r[wr_ptr_r - PTR_W'(1)];
    assign count = count_r;

endmodule

// File: rtl/dir_cmd_queue.sv
// Direction command queue: arbitrates key presses, rejects no-op and 180-degree
// turns, buffers accepted commands and releases one per game step.
module dir_cmd_queue
    import snake_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [DIR_W-1:0] INIT_DIR = 2'b11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        left_key_press,
    input  logic                        right_key_press,
    input  logic                        up_key_press,
    input  logic                        down_key_press,
    input  logic                        step,
    output logic [DIR_W-1:0]            dir,
    output logic                        step_ack,
    output logic [$clog2(DEPTH+1)-1:0]  q_count,
    output logic                        cmd_dropped
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DIR_W-1:0] dir_r;
    logic             step_ack_r;
    logic             cmd_dropped_r;

    logic             press_valid_s;
    logic [DIR_W-1:0] press_dir_s;
    logic [DIR_W-1:0] ref_dir_s;
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;

    logic [DIR_W-1:0] head_s;
    logic [DIR_W-1:0] tail_s;
    logic [CNT_W-1:0] count_s;

    // Fixed-priority pick of a single press: UP > DOWN > LEFT > RIGHT.
    always_comb begin
        press_valid_s = 1'b0;
        press_dir_s   = DIR_UP;
        if (up_key_press) begin
            press_valid_s = 1'b1;
            press_dir_s   = DIR_UP;
        end else if (down_key_press) begin
            press_valid_s = 1'b1;
            press_dir_s   = DIR_DOWN;
        end else if (left_key_press) begin
            press_valid_s = 1'b1;
            press_dir_s   = DIR_LEFT;
        end else if (right_key_press) begin
            press_valid_s = 1'b1;
            press_dir_s   = DIR_RIGHT;
        end else begin
            press_valid_s = 1'b0;
            press_dir_s   = DIR_UP;
        end
    end

    // Filter against the last queued command (pre-pop), or the live direction when empty;
    // then decide push/pop/drop. A pop in the same cycle frees room for a full queue.
    always_comb begin
        ref_dir_s = dir_r;
        accept_s  = 1'b0;
        pop_s     = 1'b0;
        push_s    = 1'b0;
        drop_s    = 1'b0;
        if (count_s != CNT_W'(0)) begin
            ref_dir_s = tail_s;
        end else begin
            ref_dir_s = dir_r;
        end
        if (press_valid_s && (press_dir_s != ref_dir_s) &&
            (press_dir_s != opposite(ref_dir_s))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (step && (count_s != CNT_W'(0))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (accept_s && ((count_s < CNT_W'(DEPTH)) || pop_s)) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else begin
            push_s = 1'b0;
            drop_s = accept_s;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (press_dir_s),
        .head  (head_s),
        .tail  (tail_s),
        .count (count_s)
    );

    // Live direction register, step acknowledge and drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_r         <= INIT_DIR;
            step_ack_r    <= 1'b0;
            cmd_dropped_r <= 1'b0;
        end else begin
            if (pop_s) begin
                dir_r <= head_s;
            end
            step_ack_r    <= step;
            cmd_dropped_r <= drop_s;
        end
    end

    assign dir         = dir_r;
    assign step_ack    = step_ack_r;
    assign q_count     = count_s;
    assign cmd_dropped = cmd_dropped_r;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Bench for dir_cmd_queue: directed vector table, wrap-around sequence, and
// random traffic against a queue-based reference model.
module tb_dir_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       left_key_press;
    logic       right_key_press;
    logic       up_key_press;
    logic       down_key_press;
    logic       step;
    logic [1:0] dir;
    logic       step_ack;
    logic [2:0] q_count;
    logic       cmd_dropped;

    int tests_run;
    int tests_failed;

    dir_cmd_queue #(
        .DEPTH    (DEPTH),
        .INIT_DIR (2'b11)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .left_key_press  (left_key_press),
        .right_key_press (right_key_press),
        .up_key_press    (up_key_press),
        .down_key_press  (down_key_press),
        .step            (step),
        .dir             (dir),
        .step_ack        (step_ack),
        .q_count         (q_count),
        .cmd_dropped     (cmd_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0] mq[$];
    logic [1:0] m_dir;
    logic       m_ack;
    logic       m_drop;
    logic [1:0] opp_tbl [4];

    task automatic model_update(input logic r, input logic u, input logic d,
                                input logic l, input logic rt, input logic s);
        logic [1:0] p;
        logic [1:0] refd;
        bit         have;
        bit         ok;
        if (r) begin
            mq.delete();
            m_dir  = 2'd3;
            m_ack  = 1'b0;
            m_drop = 1'b0;
        end else begin
            have = 1'b1;
            p    = 2'd0;
            if (u)       p = 2'd0;
            else if (d)  p = 2'd1;
            else if (l)  p = 2'd2;
            else if (rt) p = 2'd3;
            else         have = 1'b0;
            refd = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
            ok   = have && (p != refd) && (p != opp_tbl[refd]);
            m_ack  = s;
            m_drop = 1'b0;
            if (s && mq.size() > 0) m_dir = mq.pop_front();
            if (ok) begin
                if (mq.size() < DEPTH) mq.push_back(p);
                else                   m_drop = 1'b1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic u, input logic d,
                         input logic l, input logic rt, input logic s);
        reset           = r;
        up_key_press    = u;
        down_key_press  = d;
        left_key_press  = l;
        right_key_press = rt;
        step            = s;
        @(posedge clk);
        model_update(r, u, d, l, rt, s);
        #1;
        reset           = 1'b0;
        up_key_press    = 1'b0;
        down_key_press  = 1'b0;
        left_key_press  = 1'b0;
        right_key_press = 1'b0;
        step            = 1'b0;
    endtask

    task automatic press(input logic [1:0] p);
        apply(1'b0, p == 2'd0, p == 2'd1, p == 2'd2, p == 2'd3, 1'b0);
    endtask

    typedef struct {
        logic [5:0] in;   // {reset, up, down, left, right, step}
        logic [1:0] dir;
        logic       ack;
        logic [2:0] cnt;
        logic       drop;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] in, input logic [1:0] d,
                                input logic a, input logic [2:0] c, input logic dr);
        vec_t v;
        v.in = in; v.dir = d; v.ack = a; v.cnt = c; v.drop = dr;
        return v;
    endfunction

    vec_t tbl [31];
    logic [1:0] seq_a [3];
    logic [1:0] seq_b [3];
    logic [1:0] cur   [3];
    logic [5:0] vin;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        opp_tbl[0] = 2'd1; opp_tbl[1] = 2'd0; opp_tbl[2] = 2'd3; opp_tbl[3] = 2'd2;
        m_dir = 2'd3; m_ack = 1'b0; m_drop = 1'b0;
        reset = 1'b1; up_key_press = 1'b0; down_key_press = 1'b0;
        left_key_press = 1'b0; right_key_press = 1'b0; step = 1'b0;

        //                 r u d l r s   dir  ack   cnt   drop
        tbl[0]  = mk(6'b100000, 2'd3, 1'b0, 3'd0, 1'b0); // reset
        tbl[1]  = mk(6'b000001, 2'd3, 1'b1, 3'd0, 1'b0); // 3 steps, empty
        tbl[2]  = mk(6'b000001, 2'd3, 1'b1, 3'd0, 1'b0);
        tbl[3]  = mk(6'b000001, 2'd3, 1'b1, 3'd0, 1'b0);
        tbl[4]  = mk(6'b000000, 2'd3, 1'b0, 3'd0, 1'b0);
        tbl[5]  = mk(6'b010000, 2'd3, 1'b0, 3'd1, 1'b0); // UP
        tbl[6]  = mk(6'b000100, 2'd3, 1'b0, 3'd2, 1'b0); // LEFT
        tbl[7]  = mk(6'b000001, 2'd0, 1'b1, 3'd1, 1'b0);
        tbl[8]  = mk(6'b000001, 2'd2, 1'b1, 3'd0, 1'b0);
        tbl[9]  = mk(6'b100000, 2'd3, 1'b0, 3'd0, 1'b0);
        tbl[10] = mk(6'b000100, 2'd3, 1'b0, 3'd0, 1'b0); // LEFT from RIGHT rejected
        tbl[11] = mk(6'b000001, 2'd3, 1'b1, 3'd0, 1'b0);
        tbl[12] = mk(6'b010000, 2'd3, 1'b0, 3'd1, 1'b0); // fill UP,LEFT,DOWN,RIGHT
        tbl[13] = mk(6'b000100, 2'd3, 1'b0, 3'd2, 1'b0);
        tbl[14] = mk(6'b001000, 2'd3, 1'b0, 3'd3, 1'b0);
        tbl[15] = mk(6'b000010, 2'd3, 1'b0, 3'd4, 1'b0);
        tbl[16] = mk(6'b010000, 2'd3, 1'b0, 3'd4, 1'b1); // full -> drop
        tbl[17] = mk(6'b000000, 2'd3, 1'b0, 3'd4, 1'b0); // drop is one cycle
        tbl[18] = mk(6'b010001, 2'd0, 1'b1, 3'd4, 1'b0); // full + step + UP
        tbl[19] = mk(6'b000000, 2'd0, 1'b0, 3'd4, 1'b0);
        tbl[20] = mk(6'b100000, 2'd3, 1'b0, 3'd0, 1'b0); // reset mid-queue
        tbl[21] = mk(6'b010100, 2'd3, 1'b0, 3'd1, 1'b0); // UP+LEFT -> only UP
        tbl[22] = mk(6'b000001, 2'd0, 1'b1, 3'd0, 1'b0);
        tbl[23] = mk(6'b001000, 2'd0, 1'b0, 3'd0, 1'b0); // DOWN from UP rejected
        tbl[24] = mk(6'b000010, 2'd0, 1'b0, 3'd1, 1'b0);
        tbl[25] = mk(6'b110001, 2'd3, 1'b0, 3'd0, 1'b0); // reset beats step+press
        tbl[26] = mk(6'b000001, 2'd3, 1'b1, 3'd0, 1'b0);
        tbl[27] = mk(6'b010000, 2'd3, 1'b0, 3'd1, 1'b0);
        tbl[28] = mk(6'b001001, 2'd0, 1'b1, 3'd0, 1'b0); // filter vs entry being popped
        tbl[29] = mk(6'b000101, 2'd0, 1'b1, 3'd1, 1'b0); // empty step + accepted push
        tbl[30] = mk(6'b000000, 2'd0, 1'b0, 3'd1, 1'b0);

        // directed vector table
        for (int i = 0; i < 31; i++) begin
            vin = tbl[i].in;
            apply(vin[5], vin[4], vin[3], vin[2], vin[1], vin[0]);
            chk($sformatf("vec%0d_dir", i),  dir,         tbl[i].dir);
            chk($sformatf("vec%0d_ack", i),  step_ack,    tbl[i].ack);
            chk($sformatf("vec%0d_cnt", i),  q_count,     tbl[i].cnt);
            chk($sformatf("vec%0d_drop", i), cmd_dropped, tbl[i].drop);
        end

        // wrap-around: rounds of three pushes then three back-to-back steps
        seq_a[0] = 2'd0; seq_a[1] = 2'd2; seq_a[2] = 2'd1; // from RIGHT ends at DOWN
        seq_b[0] = 2'd2; seq_b[1] = 2'd0; seq_b[2] = 2'd3; // from DOWN ends at RIGHT
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int rnd = 0; rnd < 5; rnd++) begin
            for (int k = 0; k < 3; k++) cur[k] = (rnd % 2 == 0) ? seq_a[k] : seq_b[k];
            for (int k = 0; k < 3; k++) press(cur[k]);
            chk($sformatf("wrap%0d_cnt", rnd), q_count, 3);
            for (int k = 0; k < 3; k++) begin
                apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                chk($sformatf("wrap%0d_dir%0d", rnd, k), dir, cur[k]);
                chk($sformatf("wrap%0d_ack%0d", rnd, k), step_ack, 1);
            end
            chk($sformatf("wrap%0d_empty", rnd), q_count, 0);
        end

        // random traffic against the reference model
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            apply($urandom_range(0, 63) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0);
            chk("rnd_dir",  dir,         m_dir);
            chk("rnd_ack",  step_ack,    m_ack);
            chk("rnd_cnt",  q_count,     mq.size());
            chk("rnd_drop", cmd_dropped, m_drop);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
